hit_judge: RTL and testbench

- Downstream of the note-chart shifter; consumes the note bit arriving at the top of the hit window and the player's fret key.
- Grades each note as PERFECT, GOOD, MISS or STRAY.
- Maintains score, combo, max combo and multiplier for the LED/HEX display path.
- Runs on CLOCK_50 and advances note timing on the same step enable that shifts the chart.

---
 rtl/hit_judge_pkg.sv | 32 +++
 rtl/hit_judge_key_press_detect.sv | 53 +++++
 rtl/hit_judge.sv | 129 ++++++++++++
 tb/tb_hit_judge.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_judge_pkg.sv
// Shared types and constants for the rhythm-game hit judge.
package hit_judge_pkg;

  // Outcome of the press evaluation in a single clock
  typedef enum logic [2:0] {
    J_NONE,
    J_PERFECT,
    J_GOOD,
    J_MISS,
    J_STRAY
  } judge_t;

  // Points per hit before the multiplier is applied
  localparam int PERFECT_PTS = 2;
  localparam int GOOD_PTS    = 1;

  // Slots of the pending vector, oldest note in LATE
  localparam int EARLY = 0;
  localparam int LINE  = 1;
  localparam int LATE  = 2;

  // Multiplier for a given streak: one step every combo_step hits, capped
  function automatic logic [2:0] calc_mult(input logic [7:0] combo,
                                           input int combo_step,
                                           input int max_mult);
    int m;
    m = 1 + int'(combo) / combo_step;
    if (m > max_mult) m = max_mult;
    return 3'(m);
  endfunction

endpackage

// File: rtl/hit_judge_key_press_detect.sv
// Fret key front end: synchroniser, falling-edge detector and
// post-press lockout so contact bounce produces a single press.
module key_press_detect #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  input  logic play,
  output logic press
);

  localparam int LW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_LOAD = LW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [LW-1:0] lockout;
  logic          accept;

  // A press is a high-to-low transition of the synced key while unlocked
  assign accept = ~sync2 & prev & (lockout == '0) & play;

  // Two-flop synchroniser plus history flop; idles high (key released)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Register the press and run the lockout down-counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      press   <= 1'b0;
      lockout <= '0;
    end else begin
      press <= accept;
      if (accept) begin
        lockout <= LOCK_LOAD;
      end else if (lockout != '0) begin
        lockout <= lockout - LW'(1);
      end
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Grades chart notes against fret presses and keeps score, streak and
// multiplier for the display path. Press is judged before step each clock.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COMBO_STEP      = 8,
  parameter int MAX_MULT        = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step,
  input  logic        note_in,
  input  logic        key_n,
  input  logic        play,
  output logic        hit_perfect,
  output logic        hit_good,
  output logic        miss,
  output logic        stray,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic [2:0]  mult
);

  logic        press;
  logic        press_ok;
  logic        step_ok;
  logic [2:0]  pend;
  logic [2:0]  pend_cleared;
  logic [2:0]  pend_next;
  judge_t      judge;
  logic        miss_now;
  logic        hit_now;
  logic [4:0]  mult_w;
  logic [4:0]  pts;
  logic [16:0] score_sum;
  logic [15:0] score_next;
  logic [7:0]  combo_next;
  logic [7:0]  max_next;
  logic [2:0]  mult_next;

  key_press_detect #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clock(clock),
    .reset(reset),
    .key_n(key_n),
    .play (play),
    .press(press)
  );

  // play=0 freezes the game; the key front end keeps tracking the pin
  assign press_ok = press & play;
  assign step_ok  = step & play;

  // Press takes the oldest pending note, then the step ages what is left
  always_comb begin
    judge        = J_NONE;
    pend_cleared = pend;
    if (press_ok) begin
      if (pend[LATE]) begin
        judge              = J_GOOD;
        pend_cleared[LATE] = 1'b0;
      end else if (pend[LINE]) begin
        judge              = J_PERFECT;
        pend_cleared[LINE] = 1'b0;
      end else if (pend[EARLY]) begin
        judge               = J_GOOD;
        pend_cleared[EARLY] = 1'b0;
      end else begin
        judge = J_STRAY;
      end
    end
    miss_now  = step_ok & pend_cleared[LATE];
    pend_next = step_ok ? {pend_cleared[1:0], note_in} : pend_cleared;
  end

  // Points, streak and multiplier derived from this clock's outcome
  always_comb begin
    hit_now = (judge == J_PERFECT) || (judge == J_GOOD);
    mult_w  = {2'b00, mult};
    case (judge)
      J_PERFECT: pts = mult_w * 5'(PERFECT_PTS);
      J_GOOD:    pts = mult_w * 5'(GOOD_PTS);
      default:   pts = 5'd0;
    endcase
    score_sum  = {1'b0, score} + {12'd0, pts};
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    // A miss in the same clock as a hit still breaks the streak
    if (miss_now || (judge == J_STRAY)) begin
      combo_next = 8'd0;
    end else if (hit_now && (combo != 8'hFF)) begin
      combo_next = combo + 8'd1;
    end else begin
      combo_next = combo;
    end

    max_next  = (combo_next > max_combo) ? combo_next : max_combo;
    mult_next = calc_mult(combo_next, COMBO_STEP, MAX_MULT);
  end

  // Register pending notes, judgement pulses and scoreboard
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend        <= 3'b000;
      hit_perfect <= 1'b0;
      hit_good    <= 1'b0;
      miss        <= 1'b0;
      stray       <= 1'b0;
      score       <= 16'd0;
      combo       <= 8'd0;
      max_combo   <= 8'd0;
      mult        <= 3'd1;
    end else begin
      pend        <= pend_next;
      hit_perfect <= (judge == J_PERFECT);
      hit_good    <= (judge == J_GOOD);
      miss        <= miss_now;
      stray       <= (judge == J_STRAY);
      score       <= score_next;
      combo       <= combo_next;
      max_combo   <= max_next;
      mult        <= mult_next;
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed scenarios plus randomized play checked
// against a note-age reference model.
module tb_hit_judge;

  localparam int DEB   = 4;
  localparam int CSTEP = 8;
  localparam int MMULT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        step = 1'b0;
  logic        note_in = 1'b0;
  logic        key_n = 1'b1;
  logic        play = 1'b1;
  logic        hit_perfect;
  logic        hit_good;
  logic        miss;
  logic        stray;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic [2:0]  mult;

  int errors = 0;
  int checks = 0;

  hit_judge #(
    .DEBOUNCE_CYCLES(DEB),
    .COMBO_STEP     (CSTEP),
    .MAX_MULT       (MMULT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .step       (step),
    .note_in    (note_in),
    .key_n      (key_n),
    .play       (play),
    .hit_perfect(hit_perfect),
    .hit_good   (hit_good),
    .miss       (miss),
    .stray      (stray),
    .score      (score),
    .combo      (combo),
    .max_combo  (max_combo),
    .mult       (mult)
  );

  always #5 clock = ~clock;

  // Reference model: live notes tracked by age in steps (1 early, 2 line,
  // 3 late, 4 expired); key presses found from the sampled key history.
  int ages[$];
  bit m_perfect, m_good, m_miss, m_stray;
  int m_score, m_combo, m_max, m_mult;
  bit h0, h1, h2, det, pn, sn;
  int cyc, last_det, a, pts;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ages.delete();
      m_perfect = 0; m_good = 0; m_miss = 0; m_stray = 0;
      m_score = 0; m_combo = 0; m_max = 0; m_mult = 1;
      h0 = 1; h1 = 1; h2 = 1; det = 0; cyc = 0; last_det = -1000;
    end else begin
      pn = det && play;
      sn = step && play;
      m_perfect = 0; m_good = 0; m_miss = 0; m_stray = 0;
      if (pn) begin
        if (ages.size() == 0) m_stray = 1;
        else begin
          a = ages.pop_front();
          if (a == 2) m_perfect = 1; else m_good = 1;
        end
      end
      if (sn) begin
        foreach (ages[i]) ages[i] = ages[i] + 1;
        if (ages.size() > 0 && ages[0] >= 4) begin
          m_miss = 1;
          void'(ages.pop_front());
        end
        if (note_in) ages.push_back(1);
      end
      pts = m_perfect ? 2 * m_mult : (m_good ? m_mult : 0);
      m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
      if (m_miss || m_stray) m_combo = 0;
      else if (m_perfect || m_good) m_combo = (m_combo >= 255) ? 255 : m_combo + 1;
      m_mult = 1 + m_combo / CSTEP;
      if (m_mult > MMULT) m_mult = MMULT;
      if (m_combo > m_max) m_max = m_combo;
      det = !h1 && h2 && play && (cyc - last_det >= DEB);
      if (det) last_det = cyc;
      h2 = h1; h1 = h0; h0 = key_n; cyc++;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1; key_n = 1; step = 0; note_in = 0; play = 1;
    wait_n(2);
    reset = 0;
    wait_n(3);
  endtask

  // One PERFECT: note stepped to the hit line, key falls alongside, 6 clocks
  task automatic do_hit();
    @(negedge clock); key_n = 0; step = 1; note_in = 1;
    @(negedge clock); note_in = 0;
    @(negedge clock); step = 0;
    @(negedge clock); key_n = 1;
    wait_n(3);
  endtask

  task automatic test_reset();
    #1 reset = 1;
    #2;
    checks++;
    if ({hit_perfect, hit_good, miss, stray, score, combo, max_combo, mult} !==
        {4'b0000, 16'd0, 8'd0, 8'd0, 3'd1}) begin
      errors++;
      $display("FAIL reset_values: got %h/%h/%h/%h score=%0d combo=%0d max=%0d mult=%0d want 0/0/0/0 0 0 0 1",
               hit_perfect, hit_good, miss, stray, score, combo, max_combo, mult);
    end
    wait_n(3);
    reset = 0;
    wait_n(4);
    checks++;
    if (mult !== 3'd1 || score !== 16'd0) begin
      errors++;
      $display("FAIL reset_idle: got score=%0d mult=%0d want 0 1", score, mult);
    end
  endtask

  task automatic test_perfect();
    @(negedge clock); step = 1; note_in = 1;
    @(negedge clock); note_in = 0;
    @(negedge clock); step = 0; key_n = 0;
    wait_n(3);
    checks++;
    if (hit_perfect !== 1'b0) begin
      errors++; $display("FAIL perfect_early: got %b want 0", hit_perfect);
    end
    @(negedge clock);
    checks++;
    if (hit_perfect !== 1'b1) begin
      errors++; $display("FAIL perfect_pulse: got %b want 1", hit_perfect);
    end
    checks++;
    if (score !== 16'd2 || combo !== 8'd1 || mult !== 3'd1) begin
      errors++;
      $display("FAIL perfect_score: got score=%0d combo=%0d mult=%0d want 2 1 1", score, combo, mult);
    end
    key_n = 1;
    wait_n(6);
  endtask

  task automatic test_miss();
    @(negedge clock); step = 1; note_in = 1;
    @(negedge clock); note_in = 0;
    wait_n(2);
    checks++;
    if (miss !== 1'b0) begin
      errors++; $display("FAIL miss_early: got %b want 0", miss);
    end
    @(negedge clock); step = 0;
    checks++;
    if (miss !== 1'b1 || combo !== 8'd0 || score !== 16'd2) begin
      errors++;
      $display("FAIL miss_pulse: got miss=%b combo=%0d score=%0d want 1 0 2", miss, combo, score);
    end
    wait_n(2);
  endtask

  task automatic test_stray_debounce();
    int strays;
    repeat (5) do_hit();
    checks++;
    if (combo !== 8'd5) begin
      errors++; $display("FAIL stray_precombo: got %0d want 5", combo);
    end
    @(negedge clock); key_n = 0;
    @(negedge clock); key_n = 1;
    @(negedge clock); key_n = 0;
    wait_n(2);
    checks++;
    if (stray !== 1'b1 || combo !== 8'd0) begin
      errors++; $display("FAIL stray_pulse: got stray=%b combo=%0d want 1 0", stray, combo);
    end
    strays = 0;
    repeat (10) begin
      @(negedge clock);
      strays += int'(stray);
    end
    checks++;
    if (strays !== 0) begin
      errors++; $display("FAIL stray_bounce: got %0d extra strays want 0", strays);
    end
    key_n = 1;
    wait_n(6);
  endtask

  task automatic test_simultaneous();
    int exp_score;
    exp_score = m_score + m_mult;
    @(negedge clock); key_n = 0; step = 1; note_in = 1;
    @(negedge clock); note_in = 0;
    wait_n(2);
    @(negedge clock); step = 0;
    checks++;
    if ({hit_good, miss, hit_perfect} !== 3'b100 || int'(score) != exp_score) begin
      errors++;
      $display("FAIL late_press_step: got good=%b miss=%b perfect=%b score=%0d want 1 0 0 %0d",
               hit_good, miss, hit_perfect, score, exp_score);
    end
    key_n = 1;
    wait_n(6);
  endtask

  task automatic test_multiplier();
    int em;
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      do_hit();
      em = (1 + i / CSTEP > MMULT) ? MMULT : 1 + i / CSTEP;
      checks++;
      if (int'(combo) != i || int'(mult) != em) begin
        errors++;
        $display("FAIL mult_ramp: hit %0d got combo=%0d mult=%0d want %0d %0d", i, combo, mult, i, em);
      end
    end
    checks++;
    if (score !== 16'd48 || max_combo !== 8'd16 || mult !== 3'd3) begin
      errors++;
      $display("FAIL mult_total: got score=%0d max=%0d mult=%0d want 48 16 3", score, max_combo, mult);
    end
    @(negedge clock); step = 1; note_in = 1;
    @(negedge clock); note_in = 0;
    wait_n(2);
    @(negedge clock); step = 0;
    checks++;
    if (miss !== 1'b1 || combo !== 8'd0 || max_combo !== 8'd16 || mult !== 3'd1) begin
      errors++;
      $display("FAIL mult_after_miss: got miss=%b combo=%0d max=%0d mult=%0d want 1 0 16 1",
               miss, combo, max_combo, mult);
    end
    wait_n(2);
  endtask

  task automatic test_random();
    logic [38:0] got, exp;
    int bad;
    apply_reset();
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      got = {hit_perfect, hit_good, miss, stray, score, combo, max_combo, mult};
      exp = {m_perfect, m_good, m_miss, m_stray, 16'(m_score), 8'(m_combo), 8'(m_max), 3'(m_mult)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle %0d: got %h want %h", c, got, exp);
      end
      if ($urandom_range(0, 3) == 0) key_n = ~key_n;
      if ($urandom_range(0, 31) == 0) play = ~play;
      step = ($urandom_range(0, 2) == 0);
      note_in = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    play = 1; step = 0; key_n = 1;
    wait_n(8);
  endtask

  task automatic test_saturation_reset();
    int strays;
    apply_reset();
    repeat (8203) do_hit();
    checks++;
    if (score !== 16'hFFF8 || mult !== 3'd4) begin
      errors++; $display("FAIL sat_preload: got score=%h mult=%0d want fff8 4", score, mult);
    end
    do_hit();
    checks++;
    if (score !== 16'hFFFF || combo !== 8'd255) begin
      errors++; $display("FAIL sat_clip: got score=%h combo=%0d want ffff 255", score, combo);
    end
    @(negedge clock); key_n = 0;
    wait_n(3);
    #2 reset = 1;
    #1;
    checks++;
    if ({hit_perfect, hit_good, miss, stray, score, combo, max_combo, mult} !==
        {4'b0000, 16'd0, 8'd0, 8'd0, 3'd1}) begin
      errors++;
      $display("FAIL async_reset: got score=%h combo=%0d max=%0d mult=%0d want 0 0 0 1",
               score, combo, max_combo, mult);
    end
    @(negedge clock); key_n = 1;
    @(negedge clock); reset = 0;
    strays = 0;
    repeat (6) begin
      @(negedge clock);
      strays += int'(stray) + int'(hit_good) + int'(hit_perfect);
    end
    checks++;
    if (strays !== 0) begin
      errors++; $display("FAIL reset_inflight: got %0d pulses want 0", strays);
    end
  endtask

  initial begin
    test_reset();
    test_perfect();
    test_miss();
    test_stray_debounce();
    test_simultaneous();
    test_multiplier();
    test_random();
    test_saturation_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
